seq_matmul_int: RTL and testbench



---
 rtl/seq_matmul_int.sv | 174 +++++++++++++++++
 tb/tb_seq_matmul_int.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_matmul_int.sv
// Sequential signed integer matrix multiplier Z = A*B using a single MAC fed from
// one-cycle-latency RAMs; results stream out row-major. Define SEQ_MATMUL_INT_SAT_EN to saturate.
module seq_matmul_int #(
  parameter int M      = 4,
  parameter int K      = 4,
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 2*DATA_W + $clog2(K) + 1,
  parameter int OUT_W  = 32,
  localparam int MW    = (M > 1) ? $clog2(M) : 1,
  localparam int KW    = (K > 1) ? $clog2(K) : 1,
  localparam int NW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [MW-1:0]     a_i,
  output logic [KW-1:0]     a_k,
  output logic [KW-1:0]     b_k,
  output logic [NW-1:0]     b_j,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [OUT_W-1:0]  z_out,
  output logic [MW-1:0]     z_i,
  output logic [NW-1:0]     z_j,
  output logic              z_stb,
  input  logic              z_ack,
  output logic              z_sat
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT, S_DONE} state_t;

  localparam logic [MW-1:0] M_LAST = MW'(M - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);

  state_t                    state_q, state_d;
  logic [MW-1:0]             i_q, i_d, ai_q;
  logic [KW-1:0]             k_q, k_d, ak_q;
  logic [NW-1:0]             j_q, j_d, bj_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      vld_q;
  logic signed [2*DATA_W-1:0] prod;
  logic                      xfer;
  logic                      last_elem;

  assign prod      = $signed(a_in) * $signed(b_in);
  assign xfer      = z_stb & z_ack;
  assign last_elem = (i_q == M_LAST) && (j_q == N_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    z_stb   = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (k_q == K_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy    = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        busy  = 1'b1;
        z_stb = 1'b1;
        if (z_ack) state_d = last_elem ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // vld_q is never high in OUT, so accumulate and clear-on-transfer never collide.
  always_comb begin
    i_d   = i_q;
    j_d   = j_q;
    k_d   = k_q;
    acc_d = acc_q;
    if (vld_q) acc_d = acc_q + ACC_W'(prod);
    if (state_q == S_IDLE && start) begin
      i_d   = '0;
      j_d   = '0;
      k_d   = '0;
      acc_d = '0;
    end
    if (rd_en) k_d = (k_q == K_LAST) ? '0 : k_q + KW'(1);
    if (xfer) begin
      acc_d = '0;
      if (j_q == N_LAST) begin
        j_d = '0;
        i_d = (i_q == M_LAST) ? '0 : i_q + MW'(1);
      end else begin
        j_d = j_q + NW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
      acc_q <= '0;
      vld_q <= 1'b0;
      ai_q  <= '0;
      ak_q  <= '0;
      bj_q  <= '0;
    end else begin
      i_q   <= i_d;
      j_q   <= j_d;
      k_q   <= k_d;
      acc_q <= acc_d;
      vld_q <= rd_en;
      if (rd_en) begin
        ai_q <= i_q;
        ak_q <= k_q;
        bj_q <= j_q;
      end
    end
  end

  // Addresses follow the counters while fetching and freeze on the last issued value otherwise.
  assign a_i = rd_en ? i_q : ai_q;
  assign a_k = rd_en ? k_q : ak_q;
  assign b_k = a_k;
  assign b_j = rd_en ? j_q : bj_q;
  assign z_i = i_q;
  assign z_j = j_q;

`ifdef SEQ_MATMUL_INT_SAT_EN
  localparam logic signed [ACC_W-1:0] Z_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Z_MIN = ~Z_MAX;

  always_comb begin
    z_out = acc_q[OUT_W-1:0];
    z_sat = 1'b0;
    if (acc_q > Z_MAX) begin
      z_out = Z_MAX[OUT_W-1:0];
      z_sat = 1'b1;
    end else if (acc_q < Z_MIN) begin
      z_out = Z_MIN[OUT_W-1:0];
      z_sat = 1'b1;
    end
  end
`else
  assign z_out = acc_q[OUT_W-1:0];
  assign z_sat = 1'b0;

  if (ACC_W > OUT_W) begin : g_trunc
    logic unused_acc_hi;
    assign unused_acc_hi = ^acc_q[ACC_W-1:OUT_W];
  end
`endif

endmodule

// File: tb/tb_seq_matmul_int.sv
// Self-checking bench for seq_matmul_int: a 2x2x2 instance with 16-bit results and a
// 2x3x1 instance with 32-bit results, checked against a plain-arithmetic matrix model.
module tb_seq_matmul_int;

  typedef struct {
    int     i;
    int     j;
    longint z;
    bit     sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance 0: M=K=N=2, OUT_W=16
  logic        start0, busy0, done0, rd_en0, z_stb0, ack0, z_sat0;
  logic [0:0]  a_i0, a_k0, b_k0, b_j0, z_i0, z_j0;
  logic [15:0] a_in0, b_in0, z_out0;
  // Instance 1: M=2, K=3, N=1, OUT_W=32
  logic        start1, busy1, done1, rd_en1, z_stb1, ack1, z_sat1;
  logic [0:0]  a_i1, b_j1, z_i1, z_j1;
  logic [1:0]  a_k1, b_k1;
  logic [15:0] a_in1, b_in1;
  logic [31:0] z_out1;

  seq_matmul_int #(.M(2), .K(2), .N(2), .DATA_W(16), .OUT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .rd_en(rd_en0),
    .a_i(a_i0), .a_k(a_k0), .b_k(b_k0), .b_j(b_j0), .a_in(a_in0), .b_in(b_in0),
    .z_out(z_out0), .z_i(z_i0), .z_j(z_j0), .z_stb(z_stb0), .z_ack(ack0), .z_sat(z_sat0)
  );

  seq_matmul_int #(.M(2), .K(3), .N(1), .DATA_W(16), .OUT_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .rd_en(rd_en1),
    .a_i(a_i1), .a_k(a_k1), .b_k(b_k1), .b_j(b_j1), .a_in(a_in1), .b_in(b_in1),
    .z_out(z_out1), .z_i(z_i1), .z_j(z_j1), .z_stb(z_stb1), .z_ack(ack1), .z_sat(z_sat1)
  );

  int ram_a [2][4][4];
  int ram_b [2][4][4];

  // Synchronous RAMs with one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en0) begin
      a_in0 <= 16'(ram_a[0][a_i0][a_k0]);
      b_in0 <= 16'(ram_b[0][b_k0][b_j0]);
    end
    if (rd_en1) begin
      a_in1 <= 16'(ram_a[1][a_i1][a_k1]);
      b_in1 <= 16'(ram_b[1][b_k1][b_j1]);
    end
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: exact dot products, then the configured conversion to a w-bit result.
  function automatic exp_t conv_model(input longint s, input int w, input int i, input int j);
    exp_t   e;
    longint lim;
    lim   = longint'(1) <<< (w - 1);
    e.i   = i;
    e.j   = j;
    e.sat = 1'b0;
`ifdef SEQ_MATMUL_INT_SAT_EN
    if (s > lim - 1) begin
      e.z = lim - 1; e.sat = 1'b1;
    end else if (s < -lim) begin
      e.z = -lim; e.sat = 1'b1;
    end else begin
      e.z = s;
    end
`else
    e.z = s & (2*lim - 1);
    if (e.z >= lim) e.z = e.z - 2*lim;
`endif
    return e;
  endfunction

  exp_t   exp_q0[$], exp_q1[$];
  longint obs0[$], obs1[$];
  int     xfer0, xfer1;

  task automatic load_expected(input int d, input int m, input int k, input int n, input int w);
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++) begin
        longint s = 0;
        for (int kk = 0; kk < k; kk++)
          s += longint'(ram_a[d][i][kk]) * longint'(ram_b[d][kk][j]);
        if (d == 0) exp_q0.push_back(conv_model(s, w, i, j));
        else        exp_q1.push_back(conv_model(s, w, i, j));
      end
  endtask

  // Compare process: every accepted result against the model, plus hold-while-stalled.
  exp_t   e0, e1;
  bit     hold0 = 1'b0, hold1 = 1'b0;
  longint hz0, hz1;
  int     hi0, hj0, hi1, hj1;

  always @(negedge clk) begin
    if (rst) begin
      if (z_stb0) begin
        check("d0_no_read_in_out", rd_en0, 0);
        if (hold0) begin
          check("d0_hold_z_out", $signed(z_out0), hz0);
          check("d0_hold_z_i", z_i0, hi0);
          check("d0_hold_z_j", z_j0, hj0);
        end
        if (ack0) begin
          check("d0_pending_expected", exp_q0.size() > 0, 1);
          if (exp_q0.size() > 0) begin
            e0 = exp_q0.pop_front();
            check("d0_z_i", z_i0, e0.i);
            check("d0_z_j", z_j0, e0.j);
            check("d0_z_out", $signed(z_out0), e0.z);
            check("d0_z_sat", z_sat0, e0.sat);
          end
          obs0.push_back(longint'($signed(z_out0)));
          xfer0++;
        end
        hold0 = !ack0;
        hz0 = longint'($signed(z_out0)); hi0 = int'(z_i0); hj0 = int'(z_j0);
      end else begin
        hold0 = 1'b0;
      end
      if (z_stb1) begin
        check("d1_no_read_in_out", rd_en1, 0);
        if (hold1) begin
          check("d1_hold_z_out", $signed(z_out1), hz1);
          check("d1_hold_z_i", z_i1, hi1);
          check("d1_hold_z_j", z_j1, hj1);
        end
        if (ack1) begin
          check("d1_pending_expected", exp_q1.size() > 0, 1);
          if (exp_q1.size() > 0) begin
            e1 = exp_q1.pop_front();
            check("d1_z_i", z_i1, e1.i);
            check("d1_z_j", z_j1, e1.j);
            check("d1_z_out", $signed(z_out1), e1.z);
            check("d1_z_sat", z_sat1, e1.sat);
          end
          obs1.push_back(longint'($signed(z_out1)));
          xfer1++;
        end
        hold1 = !ack1;
        hz1 = longint'($signed(z_out1)); hi1 = int'(z_i1); hj1 = int'(z_j1);
      end else begin
        hold1 = 1'b0;
      end
    end
  end

  // Full run on instance 0; cycle 1 is the first cycle after the edge that samples start.
  task automatic run0(input int stall, input bit restart, output int lat, output int dones);
    int  stall_left = stall;
    bit  stalled    = 1'b0;
    obs0.delete();
    xfer0 = 0;
    load_expected(0, 2, 2, 2, 16);
    lat   = -1;
    dones = 0;
    ack0  = 1'b1;
    @(posedge clk); #1 start0 = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin
        start0 = 1'b0;
        check("d0_busy_after_start", busy0, 1);
      end
      if (restart && cyc == 6) start0 = 1'b1;
      if (restart && cyc == 7) start0 = 1'b0;
      if (stall_left > 0 && (stalled || z_stb0)) begin
        if (stalled) begin
          check("d0_stall_stb_high", z_stb0, 1);
          check("d0_stall_no_read", rd_en0, 0);
        end
        stalled = 1'b1;
        ack0    = 1'b0;
        stall_left--;
      end else begin
        ack0 = 1'b1;
      end
      if (done0) begin
        dones++;
        check("d0_busy_low_at_done", busy0, 0);
        if (lat < 0) lat = cyc;
      end
      if (lat >= 0 && cyc >= lat + 5) break;
    end
    check("d0_done_seen", lat >= 0, 1);
    check("d0_results_consumed", exp_q0.size(), 0);
    check("d0_result_count", xfer0, 4);
    check("d0_done_count", dones, 1);
  endtask

  task automatic set_mats0(input int a00, a01, a10, a11, b00, b01, b10, b11);
    ram_a[0][0][0] = a00; ram_a[0][0][1] = a01; ram_a[0][1][0] = a10; ram_a[0][1][1] = a11;
    ram_b[0][0][0] = b00; ram_b[0][0][1] = b01; ram_b[0][1][0] = b10; ram_b[0][1][1] = b11;
  endtask

  initial begin
    int  lat, dones;
    bit  found;
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0; ack0 = 1'b1; ack1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_rd_en", rd_en0, 0);
    check("rst_addr", {a_i0, a_k0, b_k0, b_j0}, 0);
    check("rst_z_out", z_out0, 0);
    check("rst_z_idx", {z_i0, z_j0}, 0);
    check("rst_z_stb", z_stb0, 0);
    check("rst_z_sat", z_sat0, 0);
    check("rst_d1_busy_stb", {busy1, z_stb1, rd_en1}, 0);
    @(negedge clk) rst = 1'b1;

    // 2x2 identity times [[1,2],[3,4]]
    set_mats0(1, 0, 0, 1, 1, 2, 3, 4);
    run0(0, 1'b0, lat, dones);
    check("id_done_latency", lat, 17);
    check("id_obs_count", obs0.size(), 4);
    check("id_z00", obs0[0], 1);
    check("id_z01", obs0[1], 2);
    check("id_z10", obs0[2], 3);
    check("id_z11", obs0[3], 4);

    // Backpressure on the first result
    run0(10, 1'b0, lat, dones);
    check("bp_done_latency", lat, 17 + 10);
    check("bp_z00", obs0[0], 1);
    check("bp_z11", obs0[3], 4);

    // start pulsed mid-run is ignored
    run0(0, 1'b1, lat, dones);
    check("sb_done_latency", lat, 17);

    // Overflow: every operand full-scale negative, sum 2^31
    set_mats0(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    run0(0, 1'b0, lat, dones);
`ifdef SEQ_MATMUL_INT_SAT_EN
    check("ovf_z00", obs0[0], 32767);
`else
    check("ovf_z00", obs0[0], 0);
`endif

    // Mid-run reset during FETCH of element (1,0)
    set_mats0(2, 1, -1, 3, 5, -6, 7, 8);
    load_expected(0, 2, 2, 2, 16);
    found = 1'b0;
    dones = 0;
    @(posedge clk); #1 start0 = 1'b1;
    for (int cyc = 1; cyc <= 60 && !found; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) start0 = 1'b0;
      if (done0) dones++;
      if (rd_en0 && a_i0 == 1'b1 && a_k0 == 1'b0) found = 1'b1;
    end
    check("mr_reached_fetch_10", found, 1);
    #2 rst = 1'b0;
    #1;
    check("mr_busy", busy0, 0);
    check("mr_rd_en", rd_en0, 0);
    check("mr_addr", {a_i0, a_k0, b_k0, b_j0}, 0);
    check("mr_z_out", z_out0, 0);
    check("mr_z_idx", {z_i0, z_j0}, 0);
    check("mr_z_stb_sat_done", {z_stb0, z_sat0, done0}, 0);
    check("mr_no_partial_done", dones, 0);
    exp_q0.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run0(0, 1'b0, lat, dones);
    check("mr_z00", obs0[0], 17);
    check("mr_z01", obs0[1], -4);
    check("mr_z10", obs0[2], 16);
    check("mr_z11", obs0[3], 30);

    // Rectangular signed on instance 1
    ram_a[1][0][0] = 1;  ram_a[1][0][1] = -2; ram_a[1][0][2] = 3;
    ram_a[1][1][0] = -4; ram_a[1][1][1] = 5;  ram_a[1][1][2] = -6;
    ram_b[1][0][0] = 7;  ram_b[1][1][0] = 8;  ram_b[1][2][0] = 9;
    obs1.delete();
    xfer1 = 0;
    load_expected(1, 2, 3, 1, 32);
    lat = -1;
    @(posedge clk); #1 start1 = 1'b1;
    for (int cyc = 1; cyc <= 100 && lat < 0; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) start1 = 1'b0;
      if (done1) lat = cyc;
    end
    check("rect_done_latency", lat, 2*1*(3+2) + 1);
    check("rect_results_consumed", exp_q1.size(), 0);
    check("rect_obs_count", obs1.size(), 2);
    check("rect_z0", obs1[0], 18);
    check("rect_z1", obs1[1], -42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
